// File: rtl/trng_arb_pkg.sv
// Shared types and widths for the entropy source arbiter.
package trng_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUT    = 2'd3
  } arb_state_e;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TIMER_W = 16;

endpackage

// File: rtl/rr_next_select.sv
// Round-robin finder: first eligible index after last_src, wrapping; last_src
// itself only wins when it is the sole eligible source.
module rr_next_select #(
  parameter  int unsigned NUM_SRC = 3,
  localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [SRC_W-1:0]   last_src,
  output logic [SRC_W-1:0]   next_src,
  output logic               any_eligible
);

  logic        found;
  int unsigned idx;

  always_comb begin
    next_src     = last_src;
    any_eligible = |eligible;
    found        = 1'b0;
    idx          = 0;
    // Offsets run 1..NUM_SRC so last_src is visited last.
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      idx = 32'(last_src) + off;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && eligible[SRC_W'(idx)]) begin
        found    = 1'b1;
        next_src = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/entropy_source_arbiter.sv
// Round-robin burst arbiter feeding the TRNG mixer from NUM_SRC entropy
// sources through a one-word holding register, skipping stalled sources.
module entropy_source_arbiter
  import trng_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 3,
  parameter int unsigned WORDS_PER_GRANT = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic                      clear_timeouts,
  input  logic [NUM_SRC-1:0]        src_enabled,
  input  logic [WORD_W*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ack,
  output logic [WORD_W-1:0]         out_data,
  output logic [2:0]                out_src,
  output logic                      out_valid,
  input  logic                      out_ack,
  output logic                      busy,
  output logic [NUM_SRC-1:0]        timeout_status
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  arb_state_e           state_q, state_d;
  logic [SRC_W-1:0]     last_src_q, last_src_d;
  logic [SRC_W-1:0]     cur_src_q, cur_src_d;
  logic [7:0]           word_ctr_q, word_ctr_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [WORD_W-1:0]    out_data_q, out_data_d;
  logic [2:0]           out_src_q, out_src_d;
  logic                 out_valid_q, out_valid_d;
  logic [NUM_SRC-1:0]   src_ack_q, src_ack_d;
  logic [NUM_SRC-1:0]   timeout_q, timeout_d;

  logic [NUM_SRC-1:0]   eligible;
  logic [SRC_W-1:0]     next_src;
  logic                 any_eligible;
  logic [WORD_W-1:0]    src_word [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_word[g] = src_data[g*WORD_W +: WORD_W];
  end

  assign eligible = src_mask & src_enabled;

  rr_next_select #(.NUM_SRC(NUM_SRC)) u_rr (
    .eligible     (eligible),
    .last_src     (last_src_q),
    .next_src     (next_src),
    .any_eligible (any_eligible)
  );

  always_comb begin
    state_d     = state_q;
    last_src_d  = last_src_q;
    cur_src_d   = cur_src_q;
    word_ctr_d  = word_ctr_q;
    timer_d     = timer_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    src_ack_d   = '0;
    // Clear first so a same-cycle timeout set below takes priority.
    timeout_d   = clear_timeouts ? '0 : timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && any_eligible) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (any_eligible) begin
          cur_src_d  = next_src;
          word_ctr_d = '0;
          timer_d    = '0;
          state_d    = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!eligible[cur_src_q]) begin
          last_src_d = cur_src_q;
          state_d    = ST_SELECT;
        end else if (src_valid[cur_src_q]) begin
          out_data_d           = src_word[cur_src_q];
          out_src_d            = 3'(cur_src_q);
          out_valid_d          = 1'b1;
          src_ack_d[cur_src_q] = 1'b1;
          state_d              = ST_OUT;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d[cur_src_q] = 1'b1;
          last_src_d           = cur_src_q;
          state_d              = ST_SELECT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ack) begin
          out_valid_d = 1'b0;
          word_ctr_d  = word_ctr_q + 1'b1;
          if (word_ctr_q == 8'(WORDS_PER_GRANT - 1) || !enable || !eligible[cur_src_q]) begin
            last_src_d = cur_src_q;
            state_d    = enable ? ST_SELECT : ST_IDLE;
          end else begin
            timer_d = '0;
            state_d = ST_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_src_q  <= SRC_W'(NUM_SRC - 1);
      cur_src_q   <= '0;
      word_ctr_q  <= '0;
      timer_q     <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      src_ack_q   <= '0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_src_q  <= last_src_d;
      cur_src_q   <= cur_src_d;
      word_ctr_q  <= word_ctr_d;
      timer_q     <= timer_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      src_ack_q   <= src_ack_d;
      timeout_q   <= timeout_d;
    end
  end

  assign src_ack        = src_ack_q;
  assign out_data       = out_data_q;
  assign out_src        = out_src_q;
  assign out_valid      = out_valid_q;
  assign busy           = (state_q != ST_IDLE);
  assign timeout_status = timeout_q;

endmodule
